// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: state encoding, opcodes, alu_op codes, mux select codes, ctrl_t bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXEC  = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_IEXEC  = 4'd9,
    ST_IWB    = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // alu_op codes, as understood by the ALU control decoder
  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  // ALU operand B select
  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
  localparam logic [2:0] SRCB_ZEXT    = 3'd4;
  localparam logic [2:0] SRCB_UPPER   = 3'd5;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Decoded datapath controls for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  // States that issue a memory request and wait on mem_ready
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the main control FSM and the multi-cycle datapath.
// Latency: n/a (wires only).
// Backpressure: memory stalls via mem_ready; the requester holds mem_read/mem_write.
// master = controller (drives controls), slave = datapath (drives opcode, mem_ready).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       branch_eq;
  logic       branch_ne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_op;
  logic       mem_err;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           pc_source, alu_op, mem_err, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           pc_source, alu_op, mem_err, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// State/opcode to datapath-control decode for the multi-cycle control FSM.
// Latency: combinational, zero cycles.
// Backpressure: none; FETCH ir_write/pc_write follow mem_ready directly.
// Ports: state, opcode, mem_ready in; ctrl (ctrl_t bundle) out.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // Only Mealy outputs: latch IR and PC+4 in the cycle memory answers
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Precompute branch target into ALUOut
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_SEXT_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_REXEC: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.branch_eq = (opcode == OP_BEQ);
        ctrl.branch_ne = (opcode == OP_BNE);
      end
      ST_IEXEC: begin
        case (opcode)
          OP_ADDI: begin
            ctrl.alu_src_a = SRCA_A;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADDI;
          end
          OP_ANDI: begin
            ctrl.alu_src_a = SRCA_A;
            ctrl.alu_src_b = SRCB_ZEXT;
            ctrl.alu_op    = ALU_AND;
          end
          OP_LUI: begin
            // 0 + (imm << 16)
            ctrl.alu_src_a = SRCA_ZERO;
            ctrl.alu_src_b = SRCB_UPPER;
            ctrl.alu_op    = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/wb).
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold their request until mem_ready; abort to FETCH after WAIT_MAX waits.
// Ports: clk, rst_n (async, active-low), bus (multicycle_control_if.master).
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15  // 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       run;
  logic       timeout;
  logic       illegal_nxt;
  logic       at_limit;
  logic       mem_err_q, illegal_q;
  ctrl_t      dec, ctrl;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // run is low during reset and for the cycle in which rst_n is released,
  // so the first request appears one cycle after release and all controls
  // drop asynchronously the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      run       <= 1'b1;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_q <= timeout;
      illegal_q <= illegal_nxt;
    end
  end

  // Timeout fires in the cycle where the counter already equals WAIT_MAX and
  // memory still has not answered; mem_ready in that cycle completes normally.
  assign at_limit = (wait_cnt == WAIT_LIM) && !bus.mem_ready;

  always_comb begin
    state_nxt    = state;
    timeout      = 1'b0;
    illegal_nxt  = 1'b0;
    wait_cnt_nxt = '0;

    case (state)
      ST_FETCH: begin
        if (bus.mem_ready) state_nxt = ST_DECODE;
        else if (at_limit) timeout   = 1'b1;
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:            state_nxt = ST_MEMADR;
          OP_RTYPE:                state_nxt = ST_REXEC;
          OP_BEQ, OP_BNE:          state_nxt = ST_BRANCH;
          OP_ADDI, OP_ANDI, OP_LUI: state_nxt = ST_IEXEC;
          OP_J:                    state_nxt = ST_JUMP;
          default: begin
            state_nxt   = ST_FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      ST_MEMADR: state_nxt = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        if (bus.mem_ready) state_nxt = ST_MEMWB;
        else if (at_limit) begin
          state_nxt = ST_FETCH;  // skip write-back
          timeout   = 1'b1;
        end
      end
      ST_MEMWR: begin
        if (bus.mem_ready) state_nxt = ST_FETCH;
        else if (at_limit) begin
          state_nxt = ST_FETCH;
          timeout   = 1'b1;
        end
      end
      ST_REXEC:  state_nxt = ST_ALUWB;
      ST_IEXEC:  state_nxt = ST_IWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_IWB, ST_JUMP: state_nxt = ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase

    // Counter only advances while a request is stalled in place; any
    // transition (including a timeout back into FETCH) clears it.
    if (is_mem_state(state) && !bus.mem_ready && !timeout)
      wait_cnt_nxt = wait_cnt + 8'd1;

    if (!run) begin
      state_nxt    = ST_FETCH;
      timeout      = 1'b0;
      illegal_nxt  = 1'b0;
      wait_cnt_nxt = '0;
    end
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (dec)
  );

  assign ctrl = run ? dec : '0;

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.branch_eq  = ctrl.branch_eq;
  assign bus.branch_ne  = ctrl.branch_ne;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.mem_err    = mem_err_q;
  assign bus.illegal_op = illegal_q;

endmodule
